// File: rtl/urna_pkg.sv
// urna_pkg: state/screen codes, candidate codes and small decode helpers
// shared by the ballot-box session controller.
package urna_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ENTER    = 3'd1;
    localparam logic [2:0] ST_REVIEW   = 3'd2;
    localparam logic [2:0] ST_RECORDED = 3'd3;
    localparam logic [2:0] ST_CLOSED   = 3'd4;
    localparam logic [2:0] ST_WINNER   = 3'd5;
    localparam logic [2:0] ST_TOTALS1  = 3'd6;
    localparam logic [2:0] ST_TOTALS2  = 3'd7;

    // LCD screen select codes consumed by the content generator
    localparam logic [2:0] SCR_IDLE     = 3'd0;
    localparam logic [2:0] SCR_ENTER    = 3'd1;
    localparam logic [2:0] SCR_REVIEW   = 3'd2;
    localparam logic [2:0] SCR_RECORDED = 3'd3;
    localparam logic [2:0] SCR_CLOSED   = 3'd4;
    localparam logic [2:0] SCR_WINNER   = 3'd5;
    localparam logic [2:0] SCR_TOTALS1  = 3'd6;
    localparam logic [2:0] SCR_TOTALS2  = 3'd7;

    // Candidate codes as (tens, units) digit pairs
    localparam logic [3:0] CAND1_D1 = 4'd1;
    localparam logic [3:0] CAND1_D2 = 4'd0;
    localparam logic [3:0] CAND2_D1 = 4'd1;
    localparam logic [3:0] CAND2_D2 = 4'd3;
    localparam logic [3:0] CAND3_D1 = 4'd1;
    localparam logic [3:0] CAND3_D2 = 4'd7;
    localparam logic [3:0] CAND4_D1 = 4'd5;
    localparam logic [3:0] CAND4_D2 = 4'd1;

    // Digit shown when there is no single winner
    localparam logic [3:0] NO_WIN_DIGIT = 4'hF;

    typedef enum logic [2:0] {
        CAND_C1   = 3'd0,
        CAND_C2   = 3'd1,
        CAND_C3   = 3'd2,
        CAND_C4   = 3'd3,
        CAND_NULL = 3'd4
    } cand_e;

    // One resolved button event per cycle, highest priority first
    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_CORRECT = 3'd1,
        EV_CONFIRM = 3'd2,
        EV_FINISH  = 3'd3,
        EV_NEXT    = 3'd4
    } event_e;

    // Map a latched digit pair to the tally it counts into; anything that
    // is not an exact candidate code (including non-BCD digits) is null.
    function automatic cand_e classify_vote(input logic [3:0] d1, input logic [3:0] d2);
        cand_e c;
        case ({d1, d2})
            {CAND1_D1, CAND1_D2}: c = CAND_C1;
            {CAND2_D1, CAND2_D2}: c = CAND_C2;
            {CAND3_D1, CAND3_D2}: c = CAND_C3;
            {CAND4_D1, CAND4_D2}: c = CAND_C4;
            default:              c = CAND_NULL;
        endcase
        return c;
    endfunction

    // Screen shown for each state
    function automatic logic [2:0] screen_of(input logic [2:0] st);
        logic [2:0] s;
        case (st)
            ST_IDLE:     s = SCR_IDLE;
            ST_ENTER:    s = SCR_ENTER;
            ST_REVIEW:   s = SCR_REVIEW;
            ST_RECORDED: s = SCR_RECORDED;
            ST_CLOSED:   s = SCR_CLOSED;
            ST_WINNER:   s = SCR_WINNER;
            ST_TOTALS1:  s = SCR_TOTALS1;
            ST_TOTALS2:  s = SCR_TOTALS2;
            default:     s = SCR_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/button_edge.sv
// button_edge: two-flop synchronizer for an asynchronous push-button level
// followed by a rising-edge detector, giving one pulse per press.
module button_edge (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize the raw level and remember the previous synchronized value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // High for exactly the one cycle after the synchronized level rises
    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/urna_sequencer.sv
// urna_sequencer: ballot-box session controller. Sequences the voter flow,
// counts each confirmed vote once into saturating tallies, and after the
// ballot is closed steps through the winner/totals screens.
module urna_sequencer #(
    parameter int CNT_W    = 6,
    parameter int MSG_HOLD = 50_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_next,
    input  logic             btn_confirm,
    input  logic             btn_correct,
    input  logic             btn_finish,
    input  logic [3:0]       dig1,
    input  logic [3:0]       dig2,
    output logic [2:0]       lcd_screen,
    output logic [CNT_W-1:0] tally_c1,
    output logic [CNT_W-1:0] tally_c2,
    output logic [CNT_W-1:0] tally_c3,
    output logic [CNT_W-1:0] tally_c4,
    output logic [CNT_W-1:0] tally_null,
    output logic [CNT_W-1:0] tally_total,
    output logic [3:0]       winner_d1,
    output logic [3:0]       winner_d2,
    output logic             winner_valid,
    output logic             vote_accepted,
    output logic             ballot_full
);

    import urna_pkg::*;

    // Hold counter only has to reach MSG_HOLD-1
    localparam int                HOLD_W    = (MSG_HOLD > 1) ? $clog2(MSG_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MSG_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Saturating increment shared by all tallies
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    logic w_next_ev;
    logic w_confirm_ev;
    logic w_correct_ev;
    logic w_finish_ev;

    event_e w_event;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [2:0]        r_screen;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_next;

    logic w_latch;
    logic w_discard;
    logic w_count;
    logic w_close;

    logic [3:0] r_vote_d1;
    logic [3:0] r_vote_d2;
    cand_e      w_cand;

    logic [CNT_W-1:0] r_c1, r_c2, r_c3, r_c4, r_null, r_total;
    logic [CNT_W-1:0] w_c1_next, w_c2_next, w_c3_next, w_c4_next, w_null_next, w_total_next;

    logic       r_ballot_full;
    logic       r_vote_accepted;
    logic [3:0] r_win_d1;
    logic [3:0] r_win_d2;
    logic       r_win_valid;
    logic [3:0] w_win_d1;
    logic [3:0] w_win_d2;
    logic       w_win_valid;

    button_edge u_next (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_next),
        .o_pulse (w_next_ev)
    );

    button_edge u_confirm (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_confirm),
        .o_pulse (w_confirm_ev)
    );

    button_edge u_correct (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_correct),
        .o_pulse (w_correct_ev)
    );

    button_edge u_finish (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_finish),
        .o_pulse (w_finish_ev)
    );

    // Resolve simultaneous presses: correct > confirm > finish > next
    always_comb begin
        w_event = EV_NONE;
        if (w_correct_ev) begin
            w_event = EV_CORRECT;
        end else if (w_confirm_ev) begin
            w_event = EV_CONFIRM;
        end else if (w_finish_ev) begin
            w_event = EV_FINISH;
        end else if (w_next_ev) begin
            w_event = EV_NEXT;
        end else begin
            w_event = EV_NONE;
        end
    end

    // Session FSM next-state and side-effect strobes
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_latch      = 1'b0;
        w_discard    = 1'b0;
        w_count      = 1'b0;
        w_close      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event == EV_NEXT && !r_ballot_full) begin
                    w_state_next = ST_ENTER;
                end else if (w_event == EV_FINISH) begin
                    w_state_next = ST_CLOSED;
                    w_close      = 1'b1;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_ENTER: begin
                if (w_event == EV_NEXT) begin
                    w_state_next = ST_REVIEW;
                    w_latch      = 1'b1;
                end else if (w_event == EV_FINISH) begin
                    w_state_next = ST_CLOSED;
                    w_close      = 1'b1;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_REVIEW: begin
                if (w_event == EV_CONFIRM) begin
                    w_state_next = ST_RECORDED;
                    w_hold_next  = HOLD_LOAD;
                    w_count      = 1'b1;
                end else if (w_event == EV_CORRECT) begin
                    w_state_next = ST_ENTER;
                    w_discard    = 1'b1;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_RECORDED: begin
                // Loaded with MSG_HOLD-1 on entry, so the screen shows for MSG_HOLD cycles
                if (r_hold == {HOLD_W{1'b0}}) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_hold_next = r_hold - HOLD_W'(1);
                end
            end
            ST_CLOSED: begin
                if (w_event == EV_NEXT) begin
                    w_state_next = ST_WINNER;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_WINNER: begin
                if (w_event == EV_NEXT) begin
                    w_state_next = ST_TOTALS1;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_TOTALS1: begin
                if (w_event == EV_NEXT) begin
                    w_state_next = ST_TOTALS2;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_TOTALS2: begin
                if (w_event == EV_NEXT) begin
                    w_state_next = ST_WINNER;
                end else begin
                    w_state_next = r_state;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, registered screen decode and hold counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_screen <= SCR_IDLE;
            r_hold   <= {HOLD_W{1'b0}};
        end else begin
            r_state  <= w_state_next;
            r_screen <= screen_of(w_state_next);
            r_hold   <= w_hold_next;
        end
    end

    // Vote register: captured on ENTER->REVIEW, wiped on correct
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vote_d1 <= NO_WIN_DIGIT;
            r_vote_d2 <= NO_WIN_DIGIT;
        end else if (w_latch) begin
            r_vote_d1 <= dig1;
            r_vote_d2 <= dig2;
        end else if (w_discard) begin
            r_vote_d1 <= NO_WIN_DIGIT;
            r_vote_d2 <= NO_WIN_DIGIT;
        end else begin
            r_vote_d1 <= r_vote_d1;
            r_vote_d2 <= r_vote_d2;
        end
    end

    assign w_cand = classify_vote(r_vote_d1, r_vote_d2);

    // Next tally values for a vote counted this cycle
    always_comb begin
        w_c1_next    = r_c1;
        w_c2_next    = r_c2;
        w_c3_next    = r_c3;
        w_c4_next    = r_c4;
        w_null_next  = r_null;
        w_total_next = r_total;
        if (w_count) begin
            case (w_cand)
                CAND_C1: w_c1_next   = sat_inc(r_c1);
                CAND_C2: w_c2_next   = sat_inc(r_c2);
                CAND_C3: w_c3_next   = sat_inc(r_c3);
                CAND_C4: w_c4_next   = sat_inc(r_c4);
                default: w_null_next = sat_inc(r_null);
            endcase
            w_total_next = sat_inc(r_total);
        end else begin
            w_total_next = r_total;
        end
    end

    // Tallies, full flag and the one-cycle accept pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_c1            <= {CNT_W{1'b0}};
            r_c2            <= {CNT_W{1'b0}};
            r_c3            <= {CNT_W{1'b0}};
            r_c4            <= {CNT_W{1'b0}};
            r_null          <= {CNT_W{1'b0}};
            r_total         <= {CNT_W{1'b0}};
            r_ballot_full   <= 1'b0;
            r_vote_accepted <= 1'b0;
        end else begin
            r_c1            <= w_c1_next;
            r_c2            <= w_c2_next;
            r_c3            <= w_c3_next;
            r_c4            <= w_c4_next;
            r_null          <= w_null_next;
            r_total         <= w_total_next;
            r_ballot_full   <= (w_total_next == CNT_MAX);
            r_vote_accepted <= w_count;
        end
    end

    // Strict single winner among the four candidates; ties report no winner
    always_comb begin
        w_win_d1    = NO_WIN_DIGIT;
        w_win_d2    = NO_WIN_DIGIT;
        w_win_valid = 1'b0;
        if (r_c1 > r_c2 && r_c1 > r_c3 && r_c1 > r_c4) begin
            w_win_d1    = CAND1_D1;
            w_win_d2    = CAND1_D2;
            w_win_valid = 1'b1;
        end else if (r_c2 > r_c1 && r_c2 > r_c3 && r_c2 > r_c4) begin
            w_win_d1    = CAND2_D1;
            w_win_d2    = CAND2_D2;
            w_win_valid = 1'b1;
        end else if (r_c3 > r_c1 && r_c3 > r_c2 && r_c3 > r_c4) begin
            w_win_d1    = CAND3_D1;
            w_win_d2    = CAND3_D2;
            w_win_valid = 1'b1;
        end else if (r_c4 > r_c1 && r_c4 > r_c2 && r_c4 > r_c3) begin
            w_win_d1    = CAND4_D1;
            w_win_d2    = CAND4_D2;
            w_win_valid = 1'b1;
        end else begin
            w_win_d1    = NO_WIN_DIGIT;
            w_win_d2    = NO_WIN_DIGIT;
            w_win_valid = 1'b0;
        end
    end

    // Winner is frozen at the moment the ballot closes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_win_d1    <= NO_WIN_DIGIT;
            r_win_d2    <= NO_WIN_DIGIT;
            r_win_valid <= 1'b0;
        end else if (w_close) begin
            r_win_d1    <= w_win_d1;
            r_win_d2    <= w_win_d2;
            r_win_valid <= w_win_valid;
        end else begin
            r_win_d1    <= r_win_d1;
            r_win_d2    <= r_win_d2;
            r_win_valid <= r_win_valid;
        end
    end

    assign lcd_screen    = r_screen;
    assign tally_c1      = r_c1;
    assign tally_c2      = r_c2;
    assign tally_c3      = r_c3;
    assign tally_c4      = r_c4;
    assign tally_null    = r_null;
    assign tally_total   = r_total;
    assign winner_d1     = r_win_d1;
    assign winner_d2     = r_win_d2;
    assign winner_valid  = r_win_valid;
    assign vote_accepted = r_vote_accepted;
    assign ballot_full   = r_ballot_full;

endmodule

// File: tb/tb_urna_sequencer.sv
// tb_urna_sequencer: directed bench for the ballot-box controller with a
// scoreboard of expected tallies checked at every vote_accepted pulse.
module tb_urna_sequencer;

    localparam int CNT_W    = 2;
    localparam int MSG_HOLD = 4;
    localparam int MAXV     = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             btn_next = 1'b0;
    logic             btn_confirm = 1'b0;
    logic             btn_correct = 1'b0;
    logic             btn_finish = 1'b0;
    logic [3:0]       dig1 = 4'd0;
    logic [3:0]       dig2 = 4'd0;
    logic [2:0]       lcd_screen;
    logic [CNT_W-1:0] tally_c1, tally_c2, tally_c3, tally_c4, tally_null, tally_total;
    logic [3:0]       winner_d1, winner_d2;
    logic             winner_valid, vote_accepted, ballot_full;

    int n_pass   = 0;
    int n_total  = 0;
    int n_pulse  = 0;
    int n_pushed = 0;
    int m_tally[6];            // c1, c2, c3, c4, null, total
    logic [6*CNT_W-1:0] exp_q[$];
    logic [6*CNT_W-1:0] mon_exp;
    int   hold_run = 0;
    logic hold_rst = 1'b0;

    urna_sequencer #(.CNT_W(CNT_W), .MSG_HOLD(MSG_HOLD)) dut (
        .clock         (clock),
        .reset         (reset),
        .btn_next      (btn_next),
        .btn_confirm   (btn_confirm),
        .btn_correct   (btn_correct),
        .btn_finish    (btn_finish),
        .dig1          (dig1),
        .dig2          (dig2),
        .lcd_screen    (lcd_screen),
        .tally_c1      (tally_c1),
        .tally_c2      (tally_c2),
        .tally_c3      (tally_c3),
        .tally_c4      (tally_c4),
        .tally_null    (tally_null),
        .tally_total   (tally_total),
        .winner_d1     (winner_d1),
        .winner_d2     (winner_d2),
        .winner_valid  (winner_valid),
        .vote_accepted (vote_accepted),
        .ballot_full   (ballot_full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_scr(input string tag, input int exp);
        chk(tag, 32'(lcd_screen), 32'(exp));
    endtask

    function automatic logic [6*CNT_W-1:0] dut_vec();
        return {tally_c1, tally_c2, tally_c3, tally_c4, tally_null, tally_total};
    endfunction

    function automatic logic [6*CNT_W-1:0] mvec();
        return {CNT_W'(m_tally[0]), CNT_W'(m_tally[1]), CNT_W'(m_tally[2]),
                CNT_W'(m_tally[3]), CNT_W'(m_tally[4]), CNT_W'(m_tally[5])};
    endfunction

    function automatic int cand_idx(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd1 && b == 4'd0) return 0;
        if (a == 4'd1 && b == 4'd3) return 1;
        if (a == 4'd1 && b == 4'd7) return 2;
        if (a == 4'd5 && b == 4'd1) return 3;
        return 4;
    endfunction

    // Expected {winner_d1, winner_d2, winner_valid} from the model tallies
    function automatic logic [8:0] exp_winner();
        int best;
        int cnt;
        int idx;
        best = -1;
        cnt  = 0;
        idx  = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_tally[i] > best) begin
                best = m_tally[i];
                idx  = i;
                cnt  = 1;
            end else if (m_tally[i] == best) begin
                cnt++;
            end
        end
        if (cnt != 1) return {4'hF, 4'hF, 1'b0};
        case (idx)
            0:       return {4'd1, 4'd0, 1'b1};
            1:       return {4'd1, 4'd3, 1'b1};
            2:       return {4'd1, 4'd7, 1'b1};
            default: return {4'd5, 4'd1, 1'b1};
        endcase
    endfunction

    // Model a confirmed vote and queue the tallies the DUT must show with its pulse
    task automatic model_vote(input logic [3:0] a, input logic [3:0] b);
        int idx;
        idx = cand_idx(a, b);
        if (m_tally[idx] < MAXV) m_tally[idx]++;
        if (m_tally[5] < MAXV) m_tally[5]++;
        exp_q.push_back(mvec());
        n_pushed++;
    endtask

    task automatic clear_model();
        foreach (m_tally[i]) m_tally[i] = 0;
        exp_q.delete();
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_next    = v;
            1:       btn_confirm = v;
            2:       btn_correct = v;
            default: btn_finish  = v;
        endcase
    endtask

    // Press for 'hold' cycles, release, and wait until the event has taken effect
    task automatic press(input int which, input int hold);
        @(negedge clock);
        set_btn(which, 1'b1);
        repeat (hold) @(negedge clock);
        set_btn(which, 1'b0);
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (lcd_screen !== 3'd0 && n < MSG_HOLD + 8) begin
            @(negedge clock);
            n++;
        end
        chk_scr("back_to_idle", 0);
    endtask

    task automatic cast_vote(input logic [3:0] a, input logic [3:0] b);
        dig1 = a;
        dig2 = b;
        press(0, 1);
        chk_scr("enter_screen", 1);
        press(0, 1);
        chk_scr("review_screen", 2);
        model_vote(a, b);
        press(1, 1);
        chk_scr("recorded_screen", 3);
        wait_idle();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_screen"}, 32'(lcd_screen), 32'd0);
        chk({tag, "_tallies"}, 32'(dut_vec()), 32'd0);
        chk({tag, "_winner"}, 32'({winner_d1, winner_d2, winner_valid}), 32'h1FE);
        chk({tag, "_flags"}, 32'({vote_accepted, ballot_full}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_model();
        @(negedge clock);
    endtask

    // Scoreboard consumer and RECORDED-duration monitor
    initial begin : vote_monitor
        forever begin
            @(negedge clock);
            if (vote_accepted === 1'b1) begin
                n_pulse++;
                chk("vote_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("tallies_at_vote", 32'(dut_vec()), 32'(mon_exp));
                end
            end
            if (lcd_screen == 3'd3) begin
                hold_run++;
                if (reset) hold_rst = 1'b1;
            end else if (hold_run != 0) begin
                if (!hold_rst && !reset) chk("recorded_len", 32'(hold_run), 32'(MSG_HOLD));
                hold_run = 0;
                hold_rst = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [8:0] w;
        clear_model();

        // Reset state
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clock);

        // Vote 1,3 with exact press-to-screen latency
        dig1 = 4'd1;
        dig2 = 4'd3;
        @(negedge clock);
        btn_next = 1'b1;
        @(negedge clock);
        btn_next = 1'b0;
        @(negedge clock);
        chk_scr("latency_before", 0);
        @(negedge clock);
        chk_scr("latency_at3", 1);
        repeat (2) @(negedge clock);
        press(0, 1);
        chk_scr("s1_review", 2);
        model_vote(4'd1, 4'd3);
        press(1, 1);
        chk_scr("s1_recorded", 3);
        wait_idle();
        chk("s1_c2", 32'(tally_c2), 32'd1);
        chk("s1_total", 32'(tally_total), 32'd1);
        chk("s1_pulses", 32'(n_pulse), 32'd1);

        // 9,9 corrected to 5,1; long confirm counts once
        dig1 = 4'd9;
        dig2 = 4'd9;
        press(0, 1);
        chk_scr("s2_enter", 1);
        press(0, 1);
        chk_scr("s2_review", 2);
        press(2, 1);
        chk_scr("s2_corrected", 1);
        dig1 = 4'd5;
        dig2 = 4'd1;
        press(0, 1);
        chk_scr("s2_review2", 2);
        model_vote(4'd5, 4'd1);
        press(1, 20);
        chk_scr("s2_idle", 0);
        chk("s2_null", 32'(tally_null), 32'd0);
        chk("s2_c4", 32'(tally_c4), 32'd1);
        chk("s2_total", 32'(tally_total), 32'd2);
        chk("s2_pulses", 32'(n_pulse), 32'(n_pushed));

        // Three votes fill the CNT_W=2 ballot; winner 1,0; result screens loop
        do_reset();
        cast_vote(4'd1, 4'd0);
        cast_vote(4'd1, 4'd0);
        chk("s3_not_full", 32'(ballot_full), 32'd0);
        cast_vote(4'd1, 4'd7);
        chk("s3_full", 32'(ballot_full), 32'd1);
        chk("s3_tallies", 32'(dut_vec()), 32'(mvec()));
        press(0, 1);
        chk_scr("s3_next_blocked", 0);
        w = exp_winner();
        press(3, 1);
        chk_scr("s3_closed", 4);
        chk("s3_winner", 32'({winner_d1, winner_d2, winner_valid}), 32'(w));
        press(0, 1);
        chk_scr("s3_winner_scr", 5);
        press(0, 1);
        chk_scr("s3_totals1", 6);
        press(0, 1);
        chk_scr("s3_totals2", 7);
        press(0, 1);
        chk_scr("s3_wrap", 5);
        press(1, 1);
        chk("s3_no_vote_closed", 32'(tally_total), 32'd3);

        // Confirm+correct together in REVIEW, then a tie at close from ENTER
        do_reset();
        dig1 = 4'd1;
        dig2 = 4'd0;
        press(0, 1);
        press(0, 1);
        chk_scr("s4_review", 2);
        @(negedge clock);
        btn_confirm = 1'b1;
        btn_correct = 1'b1;
        @(negedge clock);
        btn_confirm = 1'b0;
        btn_correct = 1'b0;
        repeat (3) @(negedge clock);
        chk_scr("s4_both_enter", 1);
        chk("s4_both_nocount", 32'(tally_total), 32'd0);
        press(0, 1);
        chk_scr("s4_review2", 2);
        model_vote(4'd1, 4'd0);
        press(1, 1);
        chk_scr("s4_recorded", 3);
        wait_idle();
        cast_vote(4'd1, 4'd7);
        press(0, 1);
        chk_scr("s4_enter", 1);
        w = exp_winner();
        press(3, 1);
        chk_scr("s4_closed_from_enter", 4);
        chk("s4_tie", 32'({winner_d1, winner_d2, winner_valid}), 32'(w));
        press(3, 1);
        chk_scr("s4_finish_ignored", 4);

        // Reset in the middle of the recorded-message hold
        do_reset();
        cast_vote(4'd1, 4'd3);
        cast_vote(4'd5, 4'd1);
        dig1 = 4'd1;
        dig2 = 4'd0;
        press(0, 1);
        press(0, 1);
        model_vote(4'd1, 4'd0);
        @(negedge clock);
        btn_confirm = 1'b1;
        @(negedge clock);
        btn_confirm = 1'b0;
        repeat (2) @(negedge clock);
        chk_scr("s6_recorded", 3);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("midhold");
        @(negedge clock);
        reset = 1'b0;
        clear_model();
        press(0, 1);
        chk_scr("s6_new_entry", 1);

        // Every queued expectation consumed by exactly one pulse
        repeat (2) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("pulse_count", 32'(n_pulse), 32'(n_pushed));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
